uart_rx: RTL and testbench

Serial-to-stream receiver paired with the `uart_tx` stage: it consumes the far-end serial line and produces one word per received frame on a valid/ready stream with sideband error flags. It sits between the pad-side `Uart_rx` input and the downstream stream consumer. It uses the same frame format and parameter set as the transmit stage: 1 start bit, `Word_len` data bits LSB-first, an optional parity bit, and 1 stop bit.

---
 rtl/uart_rx.sv | 175 +++++++++++++++++
 tb/tb_uart_rx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: serial-to-stream receiver (start, Word_len data LSB-first, optional parity, stop).
// Ports: clk, rst (async active-low), Uart_rx line in; rx_data/rx_data_valid/rx_data_ready
//        stream with rx_parity_err, rx_frame_err sideband and rx_overrun drop pulse.
`timescale 1ns/1ps
module uart_rx #(
    parameter int    clk_rate = 50_000_000,
    parameter int    Baud     = 115200,
    parameter int    Word_len = 8,
    parameter string PARITY   = "even"
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Uart_rx,
    output logic [Word_len-1:0] rx_data,
    output logic                rx_data_valid,
    input  logic                rx_data_ready,
    output logic                rx_parity_err,
    output logic                rx_frame_err,
    output logic                rx_overrun
);

    localparam int Baud_div = clk_rate / Baud;
    localparam int Half_div = Baud_div / 2;
    localparam int BCW      = (Baud_div > 1) ? $clog2(Baud_div) : 1;
    localparam int NCW      = $clog2(Word_len + 1);
    localparam bit PAR_EN   = (PARITY != "none");
    localparam bit PAR_ODD  = (PARITY == "odd");

    localparam logic [BCW-1:0] HALF_M1 = BCW'(Half_div - 1);
    localparam logic [BCW-1:0] FULL_M1 = BCW'(Baud_div - 1);
    localparam logic [NCW-1:0] LAST_B  = NCW'(Word_len - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e state_q, state_d;

    logic                rx_s1_q, rx_s2_q, rx_prev_q;
    logic [BCW-1:0]      baud_q, baud_d;
    logic [NCW-1:0]      bit_q, bit_d;
    logic [Word_len-1:0] shift_q, shift_d;
    logic                perr_q, perr_d;

    logic [Word_len-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                operr_q, operr_d;
    logic                oferr_q, oferr_d;
    logic                ovr_q, ovr_d;

    logic commit;
    logic load;
    logic fall;

    assign fall = rx_prev_q & ~rx_s2_q;

    // Receive FSM: counters restart on every state entry and after each sample.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        commit  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (fall) begin
                    state_d = S_START;
                    perr_d  = 1'b0;
                end
            end
            S_START: begin
                if (baud_q == HALF_M1) begin
                    baud_d  = '0;
                    state_d = rx_s2_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (baud_q == FULL_M1) begin
                    baud_d            = '0;
                    shift_d           = shift_q >> 1;
                    shift_d[Word_len-1] = rx_s2_q;
                    bit_d             = bit_q + 1'b1;
                    if (bit_q == LAST_B) begin
                        bit_d   = '0;
                        state_d = PAR_EN ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (baud_q == FULL_M1) begin
                    baud_d  = '0;
                    perr_d  = PAR_ODD ? (rx_s2_q != ~^shift_q)
                                      : (rx_s2_q != ^shift_q);
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_q == FULL_M1) begin
                    baud_d  = '0;
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                baud_d  = '0;
                bit_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Output register: a commit lands only if the slot is empty or drains this cycle.
    always_comb begin
        load    = commit & (~valid_q | rx_data_ready);
        data_d  = data_q;
        operr_d = operr_q;
        oferr_d = oferr_q;
        valid_d = valid_q;
        ovr_d   = commit & ~load;
        if (load) begin
            data_d  = shift_q;
            operr_d = PAR_EN ? perr_q : 1'b0;
            oferr_d = ~rx_s2_q;
            valid_d = 1'b1;
        end else if (valid_q && rx_data_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            operr_q   <= 1'b0;
            oferr_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_s1_q   <= Uart_rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            perr_q    <= perr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            operr_q   <= operr_d;
            oferr_q   <= oferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rx_data       = data_q;
    assign rx_data_valid = valid_q;
    assign rx_parity_err = operr_q;
    assign rx_frame_err  = oferr_q;
    assign rx_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx (even-parity DUT plus an odd-parity twin).
// Frames are driven bit by bit at Baud_div=10 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       Uart_rx = 1'b1;
    logic       rx_data_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_data_valid, rx_parity_err, rx_frame_err, rx_overrun;

    logic       odd_ready = 1'b1;
    logic [7:0] odd_data;
    logic       odd_valid, odd_perr, odd_ferr, odd_ovr;

    int checks = 0;
    int failures = 0;

    int         cap_cnt = 0;
    logic [7:0] cap_data = '0;
    logic       cap_perr = 1'b0;
    logic       cap_ferr = 1'b0;
    int         ovr_cnt = 0;
    int         vld_cyc = 0;
    int         odd_cnt = 0;
    logic [7:0] odd_cap_data = '0;
    logic       odd_cap_perr = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(
        .clk_rate(1_000_000), .Baud(100_000), .Word_len(8), .PARITY("even")
    ) u_dut (
        .clk(clk), .rst(rst), .Uart_rx(Uart_rx),
        .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .rx_data_ready(rx_data_ready), .rx_parity_err(rx_parity_err),
        .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
    );

    uart_rx #(
        .clk_rate(1_000_000), .Baud(100_000), .Word_len(8), .PARITY("odd")
    ) u_odd (
        .clk(clk), .rst(rst), .Uart_rx(Uart_rx),
        .rx_data(odd_data), .rx_data_valid(odd_valid),
        .rx_data_ready(odd_ready), .rx_parity_err(odd_perr),
        .rx_frame_err(odd_ferr), .rx_overrun(odd_ovr)
    );

    always @(negedge clk) begin
        if (rx_data_valid && rx_data_ready) begin
            cap_cnt  <= cap_cnt + 1;
            cap_data <= rx_data;
            cap_perr <= rx_parity_err;
            cap_ferr <= rx_frame_err;
        end
        if (rx_overrun) ovr_cnt <= ovr_cnt + 1;
        if (rx_data_valid) vld_cyc <= vld_cyc + 1;
        if (odd_valid && odd_ready) begin
            odd_cnt      <= odd_cnt + 1;
            odd_cap_data <= odd_data;
            odd_cap_perr <= odd_perr;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        Uart_rx = b;
        wait_cyc(10);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        wait_cyc(3);
        checks++;
        if ({rx_data, rx_data_valid, rx_parity_err, rx_frame_err, rx_overrun} !== 12'h0) begin
            failures++;
            $display("FAIL reset_outputs got data=%h v=%b p=%b f=%b o=%b want all 0",
                     rx_data, rx_data_valid, rx_parity_err, rx_frame_err, rx_overrun);
        end
        rst = 1'b1;
        wait_cyc(5);
        checks++;
        if (rx_data_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_valid got %b want 0", rx_data_valid);
        end
    endtask

    task automatic test_good_frame;
        int c0, v0;
        c0 = cap_cnt;
        v0 = vld_cyc;
        rx_data_ready = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_cyc(10);
        checks++;
        if (cap_cnt - c0 !== 1 || vld_cyc - v0 !== 1) begin
            failures++;
            $display("FAIL good_count got acc=%0d vcyc=%0d want 1/1", cap_cnt - c0, vld_cyc - v0);
        end
        checks++;
        if ({cap_data, cap_perr, cap_ferr} !== {8'hA5, 2'b00}) begin
            failures++;
            $display("FAIL good_word got %h p=%b f=%b want a5 p=0 f=0", cap_data, cap_perr, cap_ferr);
        end
    endtask

    task automatic test_parity;
        int c0, o0;
        c0 = cap_cnt;
        o0 = odd_cnt;
        rx_data_ready = 1'b1;
        send_frame(8'h01, 1'b0, 1'b1);
        wait_cyc(10);
        checks++;
        if (cap_cnt - c0 !== 1 || {cap_data, cap_perr, cap_ferr} !== {8'h01, 2'b10}) begin
            failures++;
            $display("FAIL parity_even got n=%0d %h p=%b f=%b want 1 01 p=1 f=0",
                     cap_cnt - c0, cap_data, cap_perr, cap_ferr);
        end
        checks++;
        if (odd_cnt - o0 !== 1 || {odd_cap_data, odd_cap_perr} !== {8'h01, 1'b0}) begin
            failures++;
            $display("FAIL parity_odd got n=%0d %h p=%b want 1 01 p=0",
                     odd_cnt - o0, odd_cap_data, odd_cap_perr);
        end
    endtask

    task automatic test_framing;
        int c0;
        c0 = cap_cnt;
        rx_data_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_cyc(50);
        checks++;
        if (cap_cnt - c0 !== 1 || {cap_data, cap_perr, cap_ferr} !== {8'h3C, 2'b01}) begin
            failures++;
            $display("FAIL frame_err got n=%0d %h p=%b f=%b want 1 3c p=0 f=1",
                     cap_cnt - c0, cap_data, cap_perr, cap_ferr);
        end
        checks++;
        if (rx_data_valid !== 1'b0) begin
            failures++;
            $display("FAIL frame_low_hold valid got %b want 0", rx_data_valid);
        end
        Uart_rx = 1'b1;
        wait_cyc(20);
        send_frame(8'h81, 1'b0, 1'b1);
        wait_cyc(10);
        checks++;
        if (cap_cnt - c0 !== 2 || {cap_data, cap_perr, cap_ferr} !== {8'h81, 2'b00}) begin
            failures++;
            $display("FAIL frame_recover got n=%0d %h p=%b f=%b want 2 81 p=0 f=0",
                     cap_cnt - c0, cap_data, cap_perr, cap_ferr);
        end
    endtask

    task automatic test_glitch;
        int v0, c0;
        v0 = vld_cyc;
        c0 = cap_cnt;
        rx_data_ready = 1'b1;
        Uart_rx = 1'b0;
        wait_cyc(3);
        Uart_rx = 1'b1;
        wait_cyc(40);
        checks++;
        if (vld_cyc - v0 !== 0) begin
            failures++;
            $display("FAIL glitch_valid got vcyc=%0d want 0", vld_cyc - v0);
        end
        send_frame(8'h96, 1'b0, 1'b1);
        wait_cyc(10);
        checks++;
        if (cap_cnt - c0 !== 1 || {cap_data, cap_perr, cap_ferr} !== {8'h96, 2'b00}) begin
            failures++;
            $display("FAIL glitch_recover got n=%0d %h p=%b f=%b want 1 96 p=0 f=0",
                     cap_cnt - c0, cap_data, cap_perr, cap_ferr);
        end
    endtask

    task automatic test_overrun;
        int o0, c0;
        o0 = ovr_cnt;
        c0 = cap_cnt;
        rx_data_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1);
        checks++;
        if (rx_data_valid !== 1'b1 || rx_data !== 8'h11 || ovr_cnt - o0 !== 0) begin
            failures++;
            $display("FAIL ovr_first got v=%b %h ovr=%0d want 1 11 0",
                     rx_data_valid, rx_data, ovr_cnt - o0);
        end
        send_frame(8'h22, 1'b0, 1'b1);
        wait_cyc(10);
        checks++;
        if (ovr_cnt - o0 !== 1) begin
            failures++;
            $display("FAIL ovr_pulse got %0d cycles want 1", ovr_cnt - o0);
        end
        checks++;
        if (rx_data_valid !== 1'b1 || rx_data !== 8'h11) begin
            failures++;
            $display("FAIL ovr_hold got v=%b %h want 1 11", rx_data_valid, rx_data);
        end
        rx_data_ready = 1'b1;
        wait_cyc(1);
        rx_data_ready = 1'b0;
        checks++;
        if (rx_data_valid !== 1'b0 || cap_cnt - c0 !== 1 || cap_data !== 8'h11) begin
            failures++;
            $display("FAIL ovr_drain got v=%b n=%0d %h want 0 1 11",
                     rx_data_valid, cap_cnt - c0, cap_data);
        end
    endtask

    task automatic test_reset_mid_frame;
        int c0;
        rx_data_ready = 1'b0;
        send_frame(8'hE7, 1'b1, 1'b0);
        Uart_rx = 1'b1;
        wait_cyc(20);
        checks++;
        if ({rx_data_valid, rx_data, rx_parity_err, rx_frame_err} !== {1'b1, 8'hE7, 2'b11}) begin
            failures++;
            $display("FAIL mid_pre got v=%b %h p=%b f=%b want 1 e7 1 1",
                     rx_data_valid, rx_data, rx_parity_err, rx_frame_err);
        end
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        Uart_rx = 1'b0;
        wait_cyc(5);
        rst = 1'b0;
        #1;
        checks++;
        if ({rx_data, rx_data_valid, rx_parity_err, rx_frame_err, rx_overrun} !== 12'h0) begin
            failures++;
            $display("FAIL mid_reset got data=%h v=%b p=%b f=%b o=%b want all 0",
                     rx_data, rx_data_valid, rx_parity_err, rx_frame_err, rx_overrun);
        end
        Uart_rx = 1'b1;
        wait_cyc(3);
        rst = 1'b1;
        wait_cyc(100);
        checks++;
        if (rx_data_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_no_partial valid got %b want 0", rx_data_valid);
        end
        c0 = cap_cnt;
        rx_data_ready = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b1);
        wait_cyc(10);
        checks++;
        if (cap_cnt - c0 !== 1 || {cap_data, cap_perr, cap_ferr} !== {8'h5A, 2'b00}) begin
            failures++;
            $display("FAIL mid_after got n=%0d %h p=%b f=%b want 1 5a p=0 f=0",
                     cap_cnt - c0, cap_data, cap_perr, cap_ferr);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity();
        test_framing();
        test_glitch();
        test_overrun();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
